sram_arbiter: RTL and testbench

- Parametrised external-SRAM port arbiter and sequencer.
- Replaces the single-client direct SRAM wiring of the board top level.
- Multiplexes N clients (core CPU/video, disk buffer, loader/MCU) onto one asynchronous SRAM using round-robin or fixed-priority arbitration.
- Generates WE#/OE#/data-enable timing with configurable wait states, and returns a per-client ack with registered read data.

---
 rtl/sram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// External asynchronous SRAM arbiter and sequencer.
// Multiplexes NUM_CLIENTS requesters onto one SRAM port with round-robin or fixed-priority
// arbitration, generates registered WE#/OE#/data-enable timing with configurable wait states,
// and returns a one-hot per-client ack with registered read data.
module sram_arbiter #(
   parameter int unsigned NUM_CLIENTS = 2,
   parameter int unsigned ADDR_W      = 21,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned PRIO_MODE   = 0
) (
   input  logic                          clk_sys,
   input  logic                          res_n_i,
   input  logic [NUM_CLIENTS-1:0]        req,
   input  logic [NUM_CLIENTS-1:0]        we,
   input  logic [NUM_CLIENTS*ADDR_W-1:0] addr,
   input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
   output logic [NUM_CLIENTS-1:0]        ack,
   output logic [DATA_W-1:0]             rdata,
   output logic                          busy,
   output logic [2:0]                    grant_id,
   output logic [ADDR_W-1:0]             sram_a,
   output logic [DATA_W-1:0]             sram_d_o,
   output logic                          sram_d_oe,
   input  logic [DATA_W-1:0]             sram_d_i,
   output logic                          sram_we_n,
   output logic                          sram_oe_n
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StAccess = 2'd1;
   localparam logic [1:0] StDone   = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [2:0]             ptr_q, ptr_d;
   logic                   wr_q, wr_d;
   logic [2:0]             gid_q, gid_d;
   logic [NUM_CLIENTS-1:0] ack_q, ack_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;
   logic [ADDR_W-1:0]      sa_q, sa_d;
   logic [DATA_W-1:0]      do_q, do_d;
   logic                   doe_q, doe_d;
   logic                   wen_q, wen_d;
   logic                   oen_q, oen_d;

   logic [7:0]  req_ext;
   logic [7:0]  we_ext;
   logic [7:0]  ack_onehot;
   logic [31:0] cand;
   logic        win_valid;
   logic [2:0]  win_idx;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   // Pad request/write vectors to 8 so any 3-bit client index selects a valid bit.
   always_comb begin
      req_ext = '0;
      we_ext  = '0;
      req_ext[NUM_CLIENTS-1:0] = req;
      we_ext[NUM_CLIENTS-1:0]  = we;
   end

   // Winner selection: rotating search from ptr+1, or lowest index in fixed-priority mode.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         if (PRIO_MODE != 0) begin
            cand = i;
         end else begin
            cand = (32'(ptr_q) + 32'd1 + i) % NUM_CLIENTS;
         end
         if (!win_valid && req_ext[cand[2:0]]) begin
            win_valid = 1'b1;
            win_idx   = cand[2:0];
         end
      end
   end

   assign win_addr  = addr[32'(win_idx) * ADDR_W +: ADDR_W];
   assign win_wdata = wdata[32'(win_idx) * DATA_W +: DATA_W];

   // Sequencer next state: all SRAM pins are computed here and registered below.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      wr_d       = wr_q;
      gid_d      = gid_q;
      ack_d      = '0;
      rdata_d    = rdata_q;
      sa_d       = sa_q;
      do_d       = do_q;
      doe_d      = doe_q;
      wen_d      = wen_q;
      oen_d      = oen_q;
      ack_onehot = 8'd1 << gid_q;
      case (state_q)
         StIdle: begin
            if (win_valid) begin
               state_d = StAccess;
               cnt_d   = '0;
               gid_d   = win_idx;
               if (PRIO_MODE == 0) begin
                  ptr_d = win_idx;
               end
               wr_d = we_ext[win_idx];
               sa_d = win_addr;
               if (we_ext[win_idx]) begin
                  wen_d = 1'b0;
                  doe_d = 1'b1;
                  do_d  = win_wdata;
               end else begin
                  oen_d = 1'b0;
                  doe_d = 1'b0;
               end
            end
         end
         StAccess: begin
            if (cnt_q == 4'(WAIT_STATES)) begin
               state_d = StDone;
               wen_d   = 1'b1;
               oen_d   = 1'b1;
               ack_d   = ack_onehot[NUM_CLIENTS-1:0];
               if (!wr_q) begin
                  rdata_d = sram_d_i;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StDone: begin
            // Write data was held through this cycle; release the bus now.
            state_d = StIdle;
            doe_d   = 1'b0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers; async reset releases the SRAM bus immediately.
   always_ff @(posedge clk_sys or negedge res_n_i) begin
      if (!res_n_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ptr_q   <= 3'(NUM_CLIENTS - 1);
         wr_q    <= 1'b0;
         gid_q   <= '0;
         ack_q   <= '0;
         rdata_q <= '0;
         sa_q    <= '0;
         do_q    <= '0;
         doe_q   <= 1'b0;
         wen_q   <= 1'b1;
         oen_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         wr_q    <= wr_d;
         gid_q   <= gid_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         sa_q    <= sa_d;
         do_q    <= do_d;
         doe_q   <= doe_d;
         wen_q   <= wen_d;
         oen_q   <= oen_d;
      end
   end

   assign ack       = ack_q;
   assign rdata     = rdata_q;
   assign busy      = (state_q != StIdle);
   assign grant_id  = gid_q;
   assign sram_a    = sa_q;
   assign sram_d_o  = do_q;
   assign sram_d_oe = doe_q;
   assign sram_we_n = wen_q;
   assign sram_oe_n = oen_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a round-robin instance (3 clients, 1 wait state) with a
// small SRAM model, and a fixed-priority instance (2 clients, 5 wait states) with a constant
// read pattern. Stimulus pushes expected acks; one monitor process does all checking.
module tb_sram_arbiter;

   localparam int NA = 3;
   localparam int WA = 1;
   localparam int NB = 2;
   localparam int WB = 5;
   localparam int AW = 21;
   localparam int DW = 8;

   typedef struct {
      int         client;
      bit         rd;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A signals
   logic [NA-1:0]    req_a, we_a, ack_a;
   logic [NA*AW-1:0] addr_a;
   logic [NA*DW-1:0] wdata_a;
   logic [DW-1:0]    rdata_a, a_do, a_din;
   logic             busy_a, a_doe, a_wen, a_oen;
   logic [2:0]       gid_a;
   logic [AW-1:0]    a_sa;

   // Instance B signals
   logic [NB-1:0]    req_b, we_b, ack_b;
   logic [NB*AW-1:0] addr_b;
   logic [NB*DW-1:0] wdata_b;
   logic [DW-1:0]    rdata_b, b_do, b_din;
   logic             busy_b, b_doe, b_wen, b_oen;
   logic [2:0]       gid_b;
   logic [AW-1:0]    b_sa;

   logic [7:0] mem [0:255];

   sram_arbiter #(
      .NUM_CLIENTS(NA), .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WA), .PRIO_MODE(0)
   ) u_dut_a (
      .clk_sys(clk), .res_n_i(rst_n), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
      .ack(ack_a), .rdata(rdata_a), .busy(busy_a), .grant_id(gid_a), .sram_a(a_sa),
      .sram_d_o(a_do), .sram_d_oe(a_doe), .sram_d_i(a_din), .sram_we_n(a_wen),
      .sram_oe_n(a_oen)
   );

   sram_arbiter #(
      .NUM_CLIENTS(NB), .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WB), .PRIO_MODE(1)
   ) u_dut_b (
      .clk_sys(clk), .res_n_i(rst_n), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
      .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .grant_id(gid_b), .sram_a(b_sa),
      .sram_d_o(b_do), .sram_d_oe(b_doe), .sram_d_i(b_din), .sram_we_n(b_wen),
      .sram_oe_n(b_oen)
   );

   // Asynchronous SRAM model for instance A (low address byte only)
   always @(posedge clk) if (!a_wen) mem[a_sa[7:0]] <= a_do;
   assign a_din = a_oen ? 8'h00 : mem[a_sa[7:0]];
   assign b_din = b_oen ? 8'h00 : 8'h5A;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;
   int   n_ack_a = 0;
   int   n_ack_b = 0;
   int   wrun_a = 0;
   int   orun_a = 0;
   int   orun_b = 0;
   bit   doe_drop_a = 1'b0;
   bit   finish_req = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: sole checker, sampling on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ack_a", 32'(ack_a), 0);
         chk("rst_rdata_a", 32'(rdata_a), 0);
         chk("rst_busy_a", 32'(busy_a), 0);
         chk("rst_gid_a", 32'(gid_a), 0);
         chk("rst_sa_a", 32'(a_sa), 0);
         chk("rst_do_a", 32'(a_do), 0);
         chk("rst_doe_a", 32'(a_doe), 0);
         chk("rst_wen_a", 32'(a_wen), 1);
         chk("rst_oen_a", 32'(a_oen), 1);
         chk("rst_ack_b", 32'(ack_b), 0);
         chk("rst_busy_b", 32'(busy_b), 0);
         chk("rst_sa_b", 32'(b_sa), 0);
         chk("rst_doe_b", 32'(b_doe), 0);
         chk("rst_wen_b", 32'(b_wen), 1);
         chk("rst_oen_b", 32'(b_oen), 1);
         wrun_a = 0;
         orun_a = 0;
         orun_b = 0;
         doe_drop_a = 1'b0;
      end else begin
         chk("strobe_excl_a", 32'(a_wen | a_oen), 1);
         chk("doe_vs_oe_a", 32'(a_doe & ~a_oen), 0);
         chk("strobe_excl_b", 32'(b_wen | b_oen), 1);
         chk("doe_vs_oe_b", 32'(b_doe & ~b_oen), 0);
         if (!a_wen) begin
            wrun_a++;
         end else begin
            if (wrun_a != 0) begin
               chk("we_len_a", wrun_a, WA + 1);
               chk("doe_hold_a", 32'(a_doe), 1);
               doe_drop_a = 1'b1;
            end else if (doe_drop_a) begin
               chk("doe_drop_a", 32'(a_doe), 0);
               doe_drop_a = 1'b0;
            end
            wrun_a = 0;
         end
         if (!a_oen) orun_a++;
         else begin
            if (orun_a != 0) chk("oe_len_a", orun_a, WA + 1);
            orun_a = 0;
         end
         if (!b_oen) orun_b++;
         else begin
            if (orun_b != 0) chk("oe_len_b", orun_b, WB + 1);
            orun_b = 0;
         end
         if (ack_a != '0) begin
            if (q_a.size() == 0) chk("unexpected_ack_a", 32'(ack_a), 0);
            else begin
               e = q_a.pop_front();
               chk("ack_a", 32'(ack_a), 32'(1) << e.client);
               chk("gid_a", 32'(gid_a), e.client);
               if (e.rd) chk("rdata_a", 32'(rdata_a), 32'(e.data));
               chk("ack_cycle_a", cyc, e.cyc);
            end
            n_ack_a++;
         end
         if (ack_b != '0) begin
            if (q_b.size() == 0) chk("unexpected_ack_b", 32'(ack_b), 0);
            else begin
               e = q_b.pop_front();
               chk("ack_b", 32'(ack_b), 32'(1) << e.client);
               chk("gid_b", 32'(gid_b), e.client);
               if (e.rd) chk("rdata_b", 32'(rdata_b), 32'(e.data));
               chk("ack_cycle_b", cyc, e.cyc);
            end
            n_ack_b++;
         end
      end
      if (finish_req) begin
         chk("pending_a", q_a.size(), 0);
         chk("pending_b", q_b.size(), 0);
         chk("idle_a", 32'(busy_a), 0);
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ack_a(input int target);
      for (int i = 0; i < 100 && n_ack_a < target; i++) step(1);
   endtask

   task automatic wait_ack_b(input int target);
      for (int i = 0; i < 100 && n_ack_b < target; i++) step(1);
   endtask

   // Single access on instance A; DUT must be idle and no other client requesting.
   task automatic access_a(input int k, input bit w, input logic [AW-1:0] ad,
                           input logic [DW-1:0] d, input bit rd, input logic [DW-1:0] exp_rd);
      exp_t x;
      int   tgt;
      addr_a[k*AW +: AW]  = ad;
      wdata_a[k*DW +: DW] = d;
      we_a[k]             = w;
      x.client = k;
      x.rd     = rd;
      x.data   = exp_rd;
      x.cyc    = cyc + WA + 2;
      q_a.push_back(x);
      tgt = n_ack_a + 1;
      req_a[k] = 1'b1;
      wait_ack_a(tgt);
      req_a[k] = 1'b0;
   endtask

   initial begin
      exp_t x;
      int   tgt;
      rst_n   = 1'b0;
      req_a   = '0;
      we_a    = '0;
      addr_a  = '0;
      wdata_a = '0;
      req_b   = '0;
      we_b    = '0;
      addr_b  = '0;
      wdata_b = '0;
      step(3);
      rst_n = 1'b1;
      step(2);

      // Write then read back, client 0
      access_a(0, 1'b1, 21'h00123, 8'hA5, 1'b0, 8'h00);
      step(1);
      access_a(0, 1'b0, 21'h00123, 8'h00, 1'b1, 8'hA5);
      step(1);

      // Reset in the middle of a write: no ack, bus released before any further edge
      addr_a[AW +: AW]  = 21'h00045;
      wdata_a[DW +: DW] = 8'h99;
      we_a[1]           = 1'b1;
      req_a[1]          = 1'b1;
      step(2);
      rst_n = 1'b0;
      step(2);
      req_a = '0;
      rst_n = 1'b1;
      step(1);

      // Round-robin with all three clients requesting: 0,1,2 repeated, 4 cycles apart
      addr_a[0 +: AW]       = 21'h00123;
      we_a[0]               = 1'b0;
      addr_a[AW +: AW]      = 21'h00045;
      wdata_a[DW +: DW]     = 8'h3C;
      we_a[1]               = 1'b1;
      addr_a[2*AW +: AW]    = 21'h1FF77;
      wdata_a[2*DW +: DW]   = 8'hC3;
      we_a[2]               = 1'b1;
      for (int j = 0; j < 9; j++) begin
         x.client = j % 3;
         x.rd     = (j % 3 == 0);
         x.data   = 8'hA5;
         x.cyc    = cyc + WA + 2 + 4 * j;
         q_a.push_back(x);
      end
      tgt   = n_ack_a + 9;
      req_a = 3'b111;
      wait_ack_a(tgt);
      req_a = '0;
      step(1);

      // Client 1 drops req one cycle after grant: exactly one ack, no second access
      addr_a[AW +: AW] = 21'h00045;
      we_a[1]          = 1'b0;
      x.client = 1;
      x.rd     = 1'b1;
      x.data   = 8'h3C;
      x.cyc    = cyc + WA + 2;
      q_a.push_back(x);
      tgt      = n_ack_a + 1;
      req_a[1] = 1'b1;
      step(2);
      req_a[1] = 1'b0;
      wait_ack_a(tgt);
      step(8);

      // Read back client 2's write
      access_a(2, 1'b0, 21'h1FF77, 8'h00, 1'b1, 8'hC3);
      step(2);

      // Fixed priority, 5 wait states: client 0 starves client 1 until it drops req
      addr_b = {21'h00020, 21'h00010};
      we_b   = 2'b00;
      for (int j = 0; j < 4; j++) begin
         x.client = (j == 3) ? 1 : 0;
         x.rd     = 1'b1;
         x.data   = 8'h5A;
         x.cyc    = cyc + WB + 2 + (WB + 3) * j;
         q_b.push_back(x);
      end
      tgt   = n_ack_b + 3;
      req_b = 2'b11;
      wait_ack_b(tgt);
      req_b[0] = 1'b0;
      wait_ack_b(tgt + 1);
      req_b[1] = 1'b0;
      step(4);

      finish_req = 1'b1;
      step(5);
      $display("FAIL monitor: finish not reached");
      $fatal(1);
   end

endmodule
